// File: rtl/parking_entry_gate.sv
`timescale 1ns/1ps
// Entry-lane controller: synchronizes and debounces the loop detectors, grants the lowest free
// slot, drives the barrier and emits a timed sense_entry pulse once the car has passed.
module parking_entry_gate #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int OPEN_TIMEOUT    = 1000,
  parameter int PULSE_CYCLES    = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_present,
  input  logic       car_passed,
  input  logic       GledA,
  input  logic       GledB,
  input  logic       GledC,
  input  logic       GledD,
  output logic       sense_entry,
  output logic       barrier_open,
  output logic       full_led,
  output logic [1:0] assigned_slot,
  output logic       slot_valid,
  output logic       timeout_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(OPEN_TIMEOUT + 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] T_MAX = TW'(OPEN_TIMEOUT);
  localparam logic [PW-1:0] P_MAX = PW'(PULSE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_QUAL, S_FULL, S_OPEN, S_NOTIFY, S_HOLDOFF
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            present_meta_q, present_q;
  logic            passed_meta_q, passed_q;
  logic            timeout_d;
  logic            any_free;
  logic [1:0]      free_slot;
  logic            barrier_d, sense_d, full_d, valid_d;
  logic [1:0]      slot_d;
  logic            barrier_q, sense_q, full_q, valid_q, timeout_q;
  logic [1:0]      slot_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      present_meta_q <= 1'b0;
      present_q      <= 1'b0;
      passed_meta_q  <= 1'b0;
      passed_q       <= 1'b0;
    end else begin
      present_meta_q <= car_present;
      present_q      <= present_meta_q;
      passed_meta_q  <= car_passed;
      passed_q       <= passed_meta_q;
    end
  end

  assign any_free = GledA | GledB | GledC | GledD;

  always_comb begin
    free_slot = 2'd3;
    if (GledA)      free_slot = 2'd0;
    else if (GledB) free_slot = 2'd1;
    else if (GledC) free_slot = 2'd2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dcnt_q  <= '0;
      tcnt_q  <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      tcnt_q  <= tcnt_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // dcnt starts at zero on entry to QUAL, so a car needs DEBOUNCE_CYCLES+2 consecutive samples.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    tcnt_d    = tcnt_q;
    pcnt_d    = pcnt_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (present_q) begin
          state_d = S_QUAL;
          dcnt_d  = '0;
        end
      end
      S_QUAL: begin
        if (!present_q)           state_d = S_IDLE;
        else if (dcnt_q == D_MAX) state_d = any_free ? S_OPEN : S_FULL;
        else                      dcnt_d  = dcnt_q + 1'b1;
      end
      S_FULL: begin
        if (any_free)        state_d = S_OPEN;
        else if (!present_q) state_d = S_IDLE;
      end
      S_OPEN: begin
        if (passed_q) begin
          state_d = S_NOTIFY;
          pcnt_d  = PW'(1);
        end else if (tcnt_q == T_MAX) begin
          state_d   = S_HOLDOFF;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_NOTIFY: begin
        if (pcnt_q == P_MAX) state_d = S_HOLDOFF;
        else                 pcnt_d  = pcnt_q + 1'b1;
      end
      S_HOLDOFF: begin
        if (!present_q && !passed_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_OPEN && state_q != S_OPEN) tcnt_d = TW'(1);
  end

  always_comb begin
    barrier_d = (state_d == S_OPEN);
    sense_d   = (state_d == S_NOTIFY);
    full_d    = (state_d == S_FULL);
    valid_d   = (state_d == S_OPEN) || (state_d == S_NOTIFY);
    slot_d    = slot_q;
    if (state_d == S_OPEN && state_q != S_OPEN) slot_d = free_slot;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      barrier_q <= 1'b0;
      sense_q   <= 1'b0;
      full_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      slot_q    <= 2'd0;
    end else begin
      barrier_q <= barrier_d;
      sense_q   <= sense_d;
      full_q    <= full_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      slot_q    <= slot_d;
    end
  end

  assign barrier_open  = barrier_q;
  assign sense_entry   = sense_q;
  assign full_led      = full_q;
  assign slot_valid    = valid_q;
  assign timeout_pulse = timeout_q;
  assign assigned_slot = slot_q;

endmodule

// File: tb/tb_parking_entry_gate.sv
`timescale 1ns/1ps
// Directed bench for parking_entry_gate with an event-level reference model checked every cycle.
module tb_parking_entry_gate;

  localparam int DEB = 4;
  localparam int TMO = 20;
  localparam int PUL = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       car_present = 1'b0;
  logic       car_passed = 1'b0;
  logic [3:0] gled = 4'b1111;   // {D,C,B,A}
  logic       sense_entry, barrier_open, full_led, slot_valid, timeout_pulse;
  logic [1:0] assigned_slot;

  int n_cmp = 0;
  int n_fail = 0;

  parking_entry_gate #(
    .DEBOUNCE_CYCLES(DEB), .OPEN_TIMEOUT(TMO), .PULSE_CYCLES(PUL)
  ) dut (
    .clk(clk), .reset(reset),
    .car_present(car_present), .car_passed(car_passed),
    .GledA(gled[0]), .GledB(gled[1]), .GledC(gled[2]), .GledD(gled[3]),
    .sense_entry(sense_entry), .barrier_open(barrier_open), .full_led(full_led),
    .assigned_slot(assigned_slot), .slot_valid(slot_valid), .timeout_pulse(timeout_pulse)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: car life-cycle tracked as streak length / open age / pulse countdown.
  int m_streak = 0;
  int m_open   = 0;
  int m_pulse  = 0;
  int m_slot   = 0;
  bit m_full = 0, m_cool = 0, m_to = 0;
  bit ph0 = 0, ph1 = 0, qh0 = 0, qh1 = 0;

  function automatic int lowest(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  initial begin
    bit p, s;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_streak = 0; m_open = 0; m_pulse = 0; m_slot = 0;
        m_full = 0; m_cool = 0; m_to = 0;
        ph0 = 0; ph1 = 0; qh0 = 0; qh1 = 0;
      end else begin
        p = ph1; s = qh1;
        ph1 = ph0; ph0 = car_present;
        qh1 = qh0; qh0 = car_passed;
        m_to = 0;
        if (m_open > 0) begin
          if (s) begin m_open = 0; m_pulse = PUL; end
          else if (m_open == TMO) begin m_open = 0; m_cool = 1; m_to = 1; end
          else m_open++;
        end else if (m_pulse > 0) begin
          m_pulse--;
          if (m_pulse == 0) m_cool = 1;
        end else if (m_cool) begin
          if (!p && !s) m_cool = 0;
        end else if (m_full) begin
          if (gled != 4'b0000) begin m_full = 0; m_open = 1; m_slot = lowest(gled); end
          else if (!p) m_full = 0;
        end else if (!p) begin
          m_streak = 0;
        end else begin
          m_streak++;
          if (m_streak == DEB + 2) begin
            m_streak = 0;
            if (gled != 4'b0000) begin m_open = 1; m_slot = lowest(gled); end
            else m_full = 1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("barrier_open",  barrier_open,  (m_open > 0) ? 1 : 0);
      chk("sense_entry",   sense_entry,   (m_pulse > 0) ? 1 : 0);
      chk("full_led",      full_led,      m_full);
      chk("slot_valid",    slot_valid,    (m_open > 0 || m_pulse > 0) ? 1 : 0);
      chk("assigned_slot", assigned_slot, m_slot);
      chk("timeout_pulse", timeout_pulse, m_to);
    end
  end

  task automatic find_rise(output int e_out);
    e_out = -1;
    for (int e = 0; e < 16; e++) begin
      @(negedge clk);
      if (barrier_open) begin
        e_out = e;
        return;
      end
    end
  endtask

  initial begin
    int rise, cnt_s, cnt_ovl, cnt_to, cnt_b, bad, found;
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_barrier", barrier_open, 0);
    chk("rst_sense", sense_entry, 0);
    chk("rst_valid", slot_valid, 0);
    chk("rst_slot", assigned_slot, 0);
    chk("rst_full", full_led, 0);
    chk("rst_timeout", timeout_pulse, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Single car, all slots free
    car_present = 1'b1;
    find_rise(rise);
    chk("single_rise_edge", rise, 7);
    chk("single_slot", assigned_slot, 0);
    chk("single_valid", slot_valid, 1);
    repeat (10) @(negedge clk);
    car_passed = 1'b1;
    cnt_s = 0; cnt_ovl = 0; cnt_to = 0;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      if (i == 1) car_present = 1'b0;
      if (i == 9) car_passed = 1'b0;
      if (sense_entry) cnt_s++;
      if (sense_entry && barrier_open) cnt_ovl++;
      if (timeout_pulse) cnt_to++;
    end
    chk("single_sense_len", cnt_s, 50);
    chk("single_sense_barrier_overlap", cnt_ovl, 0);
    chk("single_no_timeout", cnt_to, 0);

    // Debounce: 3-cycle pulses never qualify
    bad = 0;
    for (int r = 0; r < 8; r++) begin
      car_present = 1'b1;
      repeat (3) begin @(negedge clk); if (barrier_open || full_led || slot_valid) bad++; end
      car_present = 1'b0;
      repeat (3) begin @(negedge clk); if (barrier_open || full_led || slot_valid) bad++; end
    end
    repeat (6) @(negedge clk);
    chk("debounce_quiet", bad, 0);

    // Full lot, then slot C frees up, then the car never passes (timeout)
    gled = 4'b0000;
    car_present = 1'b1;
    repeat (15) @(negedge clk);
    chk("full_led_on", full_led, 1);
    chk("full_no_barrier", barrier_open, 0);
    gled = 4'b0100;
    @(negedge clk);
    chk("full_open_next_edge", barrier_open, 1);
    chk("full_slot_c", assigned_slot, 2);
    chk("full_led_off", full_led, 0);
    gled = 4'b1111;
    cnt_b = 1; cnt_s = 0; cnt_to = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (barrier_open) cnt_b++;
      if (sense_entry) cnt_s++;
      if (timeout_pulse) cnt_to++;
    end
    chk("timeout_open_cycles", cnt_b, 20);
    chk("timeout_pulse_count", cnt_to, 1);
    chk("timeout_no_sense", cnt_s, 0);
    chk("timeout_valid_clear", slot_valid, 0);
    car_present = 1'b0;
    repeat (8) @(negedge clk);

    // Lowest free slot, Gled change during OPEN, then reset mid-pulse
    gled = 4'b1010;
    car_present = 1'b1;
    find_rise(rise);
    chk("prio_rise_edge", rise, 7);
    chk("prio_slot_b", assigned_slot, 1);
    gled = 4'b1111;
    repeat (3) @(negedge clk);
    chk("prio_slot_held", assigned_slot, 1);
    car_passed = 1'b1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sense_entry) begin found = 1; break; end
    end
    chk("notify_reached", found, 1);
    repeat (10) @(negedge clk);
    car_present = 1'b0;
    car_passed = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("midrst_sense", sense_entry, 0);
    chk("midrst_barrier", barrier_open, 0);
    chk("midrst_valid", slot_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_idle_barrier", barrier_open, 0);

    // Fresh car after reset behaves as from IDLE
    car_present = 1'b1;
    find_rise(rise);
    chk("post_rst_rise_edge", rise, 7);
    chk("post_rst_slot", assigned_slot, 0);
    repeat (30) @(negedge clk);
    car_present = 1'b0;
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
